// File: rtl/tile_renderer.sv
// Pixel colour stage behind the VGA timing generator: renders a 20x15 tile map with a
// robot sprite overlay; two-clock input-to-output latency, with hsync/vsync delayed to match.
module tile_renderer #(
   parameter int MAP_W     = 20,
   parameter int MAP_H     = 15,
   parameter int MAP_DEPTH = 300,
   parameter int BLINK_BIT = 4
) (
   input  logic       clock_25,
   input  logic       reset_key,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       map_we,
   input  logic [8:0] map_addr,
   input  logic [3:0] map_wdata,
   input  logic [4:0] robot_col,
   input  logic [3:0] robot_row,
   output logic       map_ready,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs
);

   localparam logic [8:0] DEPTH_A   = 9'(MAP_DEPTH);
   localparam logic [8:0] LAST_ADDR = 9'(MAP_DEPTH - 1);
   localparam logic [4:0] MAP_W_C   = 5'(MAP_W);
   localparam logic [3:0] MAP_H_C   = 4'(MAP_H);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t      state_q, state_d;
   logic [8:0]  clear_addr_q, clear_addr_d;

   logic        ram_we;
   logic [8:0]  ram_waddr;
   logic [3:0]  ram_wdata;
   logic [3:0]  mem_q [MAP_DEPTH];

   logic [4:0]  col_in, row_in;
   logic [8:0]  rd_addr;
   logic [3:0]  rd_dat_q;

   logic [4:0]  lx1_q, ly1_q, col1_q, row1_q;
   logic        vid1_q, hs1_q, vs1_q;
   logic [7:0]  frame_q;

   logic        robot_hit;
   logic [23:0] rgb_d;

   // Power-up clear walks every map entry once, then hands the RAM to game logic.
   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      ram_we       = 1'b0;
      ram_waddr    = map_addr;
      ram_wdata    = map_wdata;
      case (state_q)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clear_addr_q;
            ram_wdata = 4'd0;
            if (clear_addr_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end else begin
               clear_addr_d = clear_addr_q + 9'd1;
            end
         end
         ST_RUN: begin
            ram_we = map_we && (map_addr < DEPTH_A);
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clock_25) begin
      if (!reset_key) begin
         state_q      <= ST_CLEAR;
         clear_addr_q <= 9'd0;
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
      end
   end

   assign map_ready = (state_q == ST_RUN);

   assign col_in  = pixel_x[9:5];
   assign row_in  = pixel_y[9:5];
   assign rd_addr = ({4'd0, row_in} << 4) + ({4'd0, row_in} << 2) + {4'd0, col_in};

   // Read-before-write: a same-address read in the write cycle sees the old tile.
   always_ff @(posedge clock_25) begin
      if (reset_key && ram_we) begin
         mem_q[ram_waddr] <= ram_wdata;
      end
      rd_dat_q <= (rd_addr < DEPTH_A) ? mem_q[rd_addr] : 4'd0;
   end

   always_ff @(posedge clock_25) begin
      if (!reset_key) begin
         lx1_q  <= 5'd0;
         ly1_q  <= 5'd0;
         col1_q <= 5'd0;
         row1_q <= 5'd0;
         vid1_q <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
      end else begin
         lx1_q  <= pixel_x[4:0];
         ly1_q  <= pixel_y[4:0];
         col1_q <= col_in;
         row1_q <= row_in;
         vid1_q <= video_on;
         hs1_q  <= hs_in;
         vs1_q  <= vs_in;
      end
   end

   // Frame counter advances on each vsync falling edge, in both FSM states.
   always_ff @(posedge clock_25) begin
      if (!reset_key) begin
         frame_q <= 8'd0;
      end else if (!vs_in && vs1_q) begin
         frame_q <= frame_q + 8'd1;
      end
   end

   assign robot_hit = (robot_col < MAP_W_C) && (robot_row < MAP_H_C) &&
                      (robot_col == col1_q) && ({1'b0, robot_row} == row1_q) &&
                      (lx1_q >= 5'd4) && (lx1_q <= 5'd27) &&
                      (ly1_q >= 5'd4) && (ly1_q <= 5'd27);

   always_comb begin
      rgb_d = 24'h000000;
      if (vid1_q && (state_q == ST_RUN)) begin
         if (robot_hit) begin
            rgb_d = 24'hFFFF00;
         end else begin
            case (rd_dat_q)
               4'd1:    rgb_d = 24'h808080;
               4'd2:    rgb_d = frame_q[BLINK_BIT] ? 24'h402008 : 24'h8B4513;
               4'd3:    rgb_d = 24'h00C0C0;
               default: rgb_d = 24'h000000;
            endcase
         end
      end
   end

   always_ff @(posedge clock_25) begin
      if (!reset_key) begin
         vga_r  <= 8'd0;
         vga_g  <= 8'd0;
         vga_b  <= 8'd0;
         vga_hs <= 1'b1;
         vga_vs <= 1'b1;
      end else begin
         vga_r  <= rgb_d[23:16];
         vga_g  <= rgb_d[15:8];
         vga_b  <= rgb_d[7:0];
         vga_hs <= hs1_q;
         vga_vs <= vs1_q;
      end
   end

endmodule

// File: tb/tb_tile_renderer.sv
// Randomised and directed bench for tile_renderer against a pixel-level reference model.
module tb_tile_renderer;

   logic       clock_25 = 1'b0;
   logic       reset_key;
   logic [9:0] pixel_x, pixel_y;
   logic       video_on, hs_in, vs_in;
   logic       map_we;
   logic [8:0] map_addr;
   logic [3:0] map_wdata;
   logic [4:0] robot_col;
   logic [3:0] robot_row;
   logic       map_ready;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs;

   always #20 clock_25 = ~clock_25;

   tile_renderer dut (
      .clock_25 (clock_25),
      .reset_key(reset_key),
      .pixel_x  (pixel_x),
      .pixel_y  (pixel_y),
      .video_on (video_on),
      .hs_in    (hs_in),
      .vs_in    (vs_in),
      .map_we   (map_we),
      .map_addr (map_addr),
      .map_wdata(map_wdata),
      .robot_col(robot_col),
      .robot_row(robot_row),
      .map_ready(map_ready),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b),
      .vga_hs   (vga_hs),
      .vga_vs   (vga_vs)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: tile contents, clear progress, frame count, and the pixel sampled last clock.
   int mem_m [300];
   int clear_n = 0;
   int frame_m = 0;
   int s_x = 0, s_y = 0, s_code = 0;
   bit s_vid = 0, s_hs = 1, s_vs = 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] colour(input int x, input int y, input bit vid, input int code,
                                          input int rc, input int rr, input int frame,
                                          input bit clearing);
      int lx = x % 32;
      int ly = y % 32;
      if (!vid || clearing) return 24'h000000;
      if (rc < 20 && rr < 15 && rc == x / 32 && rr == y / 32 &&
          lx >= 4 && lx <= 27 && ly >= 4 && ly <= 27) return 24'hFFFF00;
      case (code)
         1:       return 24'h808080;
         2:       return ((frame / 16) % 2 == 0) ? 24'h8B4513 : 24'h402008;
         3:       return 24'h00C0C0;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic tick(input string phase);
      logic [23:0] e_rgb;
      logic        e_hs, e_vs;
      int          a;
      @(posedge clock_25);
      if (!reset_key) begin
         e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1;
         s_vid = 0; s_hs = 1; s_vs = 1;
         frame_m = 0; clear_n = 0;
      end else begin
         e_rgb = colour(s_x, s_y, s_vid, s_code, int'(robot_col), int'(robot_row),
                        frame_m, clear_n < 300);
         e_hs = s_hs; e_vs = s_vs;
         if (!vs_in && s_vs) frame_m = (frame_m + 1) % 256;
         a = (int'(pixel_y) / 32) * 20 + int'(pixel_x) / 32;
         s_code = (a < 300) ? mem_m[a] : 0;
         s_x = int'(pixel_x); s_y = int'(pixel_y);
         s_vid = video_on; s_hs = hs_in; s_vs = vs_in;
         if (clear_n < 300) begin
            mem_m[clear_n] = 0;
            clear_n++;
         end else if (map_we && int'(map_addr) < 300) begin
            mem_m[map_addr] = int'(map_wdata);
         end
      end
      #1;
      check({phase, "_rgb"}, {8'h0, vga_r, vga_g, vga_b}, {8'h0, e_rgb});
      check({phase, "_sync"}, {30'h0, vga_hs, vga_vs}, {30'h0, e_hs, e_vs});
      check({phase, "_ready"}, {31'h0, map_ready}, {31'h0, clear_n >= 300});
   endtask

   task automatic set_px(input int x, input int y);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = (x < 640) && (y < 480);
   endtask

   task automatic rand_px();
      set_px($urandom_range(0, 799), $urandom_range(0, 524));
      hs_in = ($urandom_range(0, 3) != 0);
   endtask

   task automatic vs_pulse();
      vs_in = 1'b0; tick("vsync");
      vs_in = 1'b1; tick("vsync");
   endtask

   // Ticks from reset release until map_ready rises, bounded.
   task automatic ready_delay(input string tag);
      int n = 0;
      while (!map_ready && n < 400) begin
         rand_px();
         map_we = $urandom_range(0, 1); map_addr = 9'($urandom_range(0, 319));
         map_wdata = 4'($urandom);
         tick(tag);
         n++;
      end
      check({tag, "_delay"}, n, 300);
   endtask

   task automatic write(input int addr, input int code);
      map_we = 1'b1; map_addr = 9'(addr); map_wdata = 4'(code);
      tick("write");
      map_we = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 300; i++) mem_m[i] = 0;
      reset_key = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      map_we = 1'b0; map_addr = 9'd0; map_wdata = 4'd0;
      robot_col = 5'd31; robot_row = 4'd15;
      set_px(0, 0);
      repeat (3) tick("reset");

      reset_key = 1'b1;
      ready_delay("clear");
      map_we = 1'b0; hs_in = 1'b1;

      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++) begin
            set_px(c * 32 + 16, r * 32 + 16);
            tick("sweep");
         end

      write(21, 1);
      write(300, 3);
      set_px(40, 40); hs_in = 1'b0; tick("grey");
      hs_in = 1'b1; tick("grey");
      check("grey_rgb", {vga_r, vga_g, vga_b}, 24'h808080);
      check("grey_hs", vga_hs, 1'b0);

      map_we = 1'b1; map_addr = 9'd21; map_wdata = 4'd3;
      tick("rw");
      map_we = 1'b0;
      tick("rw");
      check("rw_old", {vga_r, vga_g, vga_b}, 24'h808080);
      tick("rw");
      check("rw_new", {vga_r, vga_g, vga_b}, 24'h00C0C0);

      write(0, 2);
      set_px(5, 5);
      for (int i = 0; i < 15; i++) vs_pulse();
      check("dirt_15", {vga_r, vga_g, vga_b}, 24'h8B4513);
      vs_pulse();
      check("dirt_16", {vga_r, vga_g, vga_b}, 24'h402008);
      for (int i = 0; i < 240; i++) vs_pulse();
      check("dirt_wrap", {vga_r, vga_g, vga_b}, 24'h8B4513);

      write(43, 3);
      robot_col = 5'd3; robot_row = 4'd2;
      set_px(100, 68); tick("robot"); tick("robot");
      check("robot_on", {vga_r, vga_g, vga_b}, 24'hFFFF00);
      set_px(99, 68); tick("robot"); tick("robot");
      check("robot_edge", {vga_r, vga_g, vga_b}, 24'h00C0C0);
      set_px(100, 68); video_on = 1'b0; tick("robot"); tick("robot");
      check("robot_blank", {vga_r, vga_g, vga_b}, 24'h000000);
      robot_col = 5'd20; set_px(660, 68); tick("robot"); tick("robot");

      reset_key = 1'b0; tick("rst2");
      reset_key = 1'b1;
      for (int i = 0; i < 150; i++) begin
         rand_px(); tick("midclr");
      end
      reset_key = 1'b0; tick("rst3");
      reset_key = 1'b1;
      ready_delay("reclear");

      for (int i = 0; i < 3000; i++) begin
         rand_px();
         vs_in = ($urandom_range(0, 7) != 0);
         map_we = ($urandom_range(0, 3) == 0);
         map_addr = 9'($urandom_range(0, 319));
         map_wdata = 4'($urandom_range(0, 5));
         if ($urandom_range(0, 31) == 0) begin
            robot_col = 5'($urandom_range(0, 23));
            robot_row = 4'($urandom_range(0, 15));
         end
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
